serial_addsub_digit: RTL and testbench

- Parametrised digit-serial adder/subtractor; successor to the team's 1-bit serial adder.
- Accepts two WIDTH-bit operands over independent valid/ready channels.
- Processes DIGIT bits per clock, LSB first, for WIDTH/DIGIT cycles.
- Returns sum, carry-out and signed-overflow over a valid/ready output channel.
- Add/subtract mode is chosen per transaction. Sits between operand producers and a downstream consumer in the fixed-point datapath.

---
 rtl/serial_arith_pkg.sv | 23 ++
 rtl/serial_addsub_digit_if.sv | 31 +++
 rtl/serial_digit_adder.sv | 14 +
 rtl/serial_addsub_digit.sv | 171 +++++++++++++++++
 tb/tb_serial_addsub_digit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the digit-serial add/subtract datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Ceiling log2, used to size the digit-step counter at elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_digit_if.sv
// Operand, op-select and result channels of the digit-serial adder/subtractor.
// Latency: none (wiring only).
// Backpressure: each channel is an independent valid/ready pair.
interface serial_addsub_digit_if #(
  parameter int WIDTH = 64
) ();
  logic [WIDTH-1:0] x;
  logic             op;
  logic             data_x_vld;
  logic             data_x_rdy;
  logic [WIDTH-1:0] y;
  logic             data_y_vld;
  logic             data_y_rdy;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             d_out_vld;
  logic             d_out_rdy;

  // Producer/consumer side.
  modport master (
    output x, op, data_x_vld, y, data_y_vld, d_out_rdy,
    input  data_x_rdy, data_y_rdy, sum, cout, ovf, d_out_vld
  );

  // Arithmetic unit side.
  modport slave (
    input  x, op, data_x_vld, y, data_y_vld, d_out_rdy,
    output data_x_rdy, data_y_rdy, sum, cout, ovf, d_out_vld
  );
endinterface

// File: rtl/serial_digit_adder.sv
// DIGIT-bit ripple adder with carry in/out, one digit step of the serial unit.
// Latency: combinational.
// Backpressure: none.
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial X+Y / X-Y over two operand channels, LSB first, DIGIT bits per cycle.
// Latency: capture edge, one load edge, then WIDTH/DIGIT compute edges to d_out_vld.
// Backpressure: result held in DONE until d_out_rdy; operands refused outside IDLE.
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input logic                  clk,
  input logic                  asyn_reset,
  serial_addsub_digit_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_addsub_digit: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_reg, y_reg, res_reg, res_nxt, s_ext;
  logic             op_reg, carry, x_hit, y_hit;
  logic [CNT_W-1:0] cnt;
  logic             x_rdy, y_rdy, out_vld;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, ovf_reg;
  logic             x_take, y_take, start, last_step, out_take;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c;

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (x_reg[DIGIT-1:0]),
    .b    (y_reg[DIGIT-1:0]),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_c)
  );

  // New digit enters the result register from the top; after STEPS shifts it is aligned.
  assign s_ext   = WIDTH'(dig_s);
  assign res_nxt = (res_reg >> DIGIT) | (s_ext << (WIDTH - DIGIT));

  // State register.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    x_take    = 1'b0;
    y_take    = 1'b0;
    start     = 1'b0;
    last_step = 1'b0;
    out_take  = 1'b0;
    case (state)
      IDLE: begin
        x_take = x_rdy && bus.data_x_vld;
        y_take = y_rdy && bus.data_y_vld;
        if (x_hit && y_hit) begin
          start     = 1'b1;
          state_nxt = COMP;
        end
      end
      COMP: begin
        if (cnt == LAST_CNT) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_vld && bus.d_out_rdy) begin
          out_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand handshakes: a channel is ready in IDLE until it has been captured once.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      x_hit <= 1'b0;
      y_hit <= 1'b0;
      x_rdy <= 1'b0;
      y_rdy <= 1'b0;
    end else begin
      if (x_take) begin
        x_hit <= 1'b1;
        x_rdy <= 1'b0;
      end else if ((state == IDLE) && !x_hit) begin
        x_rdy <= 1'b1;
      end
      if (y_take) begin
        y_hit <= 1'b1;
        y_rdy <= 1'b0;
      end else if ((state == IDLE) && !y_hit) begin
        y_rdy <= 1'b1;
      end
      if (start) begin
        x_hit <= 1'b0;
        y_hit <= 1'b0;
      end
      if (out_take) begin
        x_rdy <= 1'b1;
        y_rdy <= 1'b1;
      end
    end
  end

  // Operand capture, subtract set-up (X + ~Y + 1) and the digit-serial shift datapath.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      x_reg   <= '0;
      y_reg   <= '0;
      res_reg <= '0;
      op_reg  <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (x_take) begin
        x_reg  <= bus.x;
        op_reg <= bus.op;
      end
      if (y_take) y_reg <= bus.y;
      if (start) begin
        cnt   <= '0;
        carry <= (op_reg == OP_SUB);
        if (op_reg == OP_SUB) y_reg <= ~y_reg;
      end
      if (state == COMP) begin
        x_reg   <= x_reg >> DIGIT;
        y_reg   <= y_reg >> DIGIT;
        res_reg <= res_nxt;
        carry   <= dig_c;
        cnt     <= cnt + CNT_W'(1);
      end
    end
  end

  // Result registers: loaded on the last digit step, held until overwritten.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      if (last_step) begin
        sum_reg  <= res_nxt;
        cout_reg <= dig_c;
        // Carry into the MSB (x^y^s at the MSB) differs from carry out on overflow.
        ovf_reg  <= x_reg[DIGIT-1] ^ y_reg[DIGIT-1] ^ dig_s[DIGIT-1] ^ dig_c;
        out_vld  <= 1'b1;
      end
      if (out_take) out_vld <= 1'b0;
    end
  end

  assign bus.data_x_rdy = x_rdy;
  assign bus.data_y_rdy = y_rdy;
  assign bus.sum        = sum_reg;
  assign bus.cout       = cout_reg;
  assign bus.ovf        = ovf_reg;
  assign bus.d_out_vld  = out_vld;

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Bench for serial_addsub_digit over several WIDTH/DIGIT builds sharing one driver.
// Latency: expects WIDTH/DIGIT compute cycles after the load edge.
// Backpressure: exercises output stalls and operand presentation outside IDLE.
module tb_serial_addsub_digit;
  import serial_arith_pkg::*;

  localparam int NI = 9;

  function automatic int w_of(input int i);
    if (i < 3)  return 8;
    if (i == 3) return 64;
    return 16;
  endfunction

  function automatic int d_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      3:       return 1;
      4:       return 1;
      5:       return 2;
      6:       return 4;
      7:       return 8;
      default: return 16;
    endcase
  endfunction

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cap;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        asyn_reset = 1'b1;
  int          sel = 0;
  logic [63:0] g_x = '0, g_y = '0;
  logic        g_op = 1'b0, g_xv = 1'b0, g_yv = 1'b0, g_rdy = 1'b0;
  bit          stall_en = 1'b0;
  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  exp_t        sb[$];

  logic [63:0] o_sum [NI];
  logic        o_cout [NI], o_ovf [NI], o_vld [NI], o_xr [NI], o_yr [NI];
  logic [63:0] m_sum;
  logic        m_cout, m_ovf, m_vld, m_xr, m_yr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = w_of(g);
    localparam int D = d_of(g);
    serial_addsub_digit_if #(.WIDTH(W)) bus ();
    assign bus.x          = g_x[W-1:0];
    assign bus.op         = g_op;
    assign bus.data_x_vld = g_xv && (sel == g);
    assign bus.y          = g_y[W-1:0];
    assign bus.data_y_vld = g_yv && (sel == g);
    assign bus.d_out_rdy  = g_rdy && (sel == g);
    assign o_sum[g]  = 64'(bus.sum);
    assign o_cout[g] = bus.cout;
    assign o_ovf[g]  = bus.ovf;
    assign o_vld[g]  = bus.d_out_vld;
    assign o_xr[g]   = bus.data_x_rdy;
    assign o_yr[g]   = bus.data_y_rdy;
    serial_addsub_digit #(.WIDTH(W), .DIGIT(D)) dut (
      .clk        (clk),
      .asyn_reset (asyn_reset),
      .bus        (bus.slave)
    );
  end

  assign m_sum  = o_sum[sel];
  assign m_cout = o_cout[sel];
  assign m_ovf  = o_ovf[sel];
  assign m_vld  = o_vld[sel];
  assign m_xr   = o_xr[sel];
  assign m_yr   = o_yr[sel];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: X + (op ? ~Y : Y) + op at width w, overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic op);
    exp_t        r;
    logic [63:0] mask, xx, yy, s;
    logic [64:0] full;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xx     = x & mask;
    yy     = (op ? ~y : y) & mask;
    full   = {1'b0, xx} + {1'b0, yy} + 65'(op);
    s      = full[63:0] & mask;
    r.sum  = s;
    r.cout = full[w];
    r.ovf  = (xx[w-1] == yy[w-1]) && (s[w-1] != xx[w-1]);
    r.cap  = 0;
    r.lat  = 0;
    return r;
  endfunction

  // Present X/op and Y after their own delays; push the expectation on capture.
  task automatic drive_txn(input logic [63:0] x, input logic [63:0] y, input logic op,
                           input int x_delay, input int y_delay, input bit push,
                           input logic [63:0] e_sum, input logic e_cout, input logic e_ovf);
    bit   xd, yd;
    int   t;
    exp_t e;
    xd = 1'b0; yd = 1'b0; t = 0;
    e.sum = e_sum; e.cout = e_cout; e.ovf = e_ovf; e.cap = 0;
    e.lat = w_of(sel) / d_of(sel);
    g_x = x; g_y = y; g_op = op;
    while (!(xd && yd)) begin
      g_xv = !xd && (t >= x_delay);
      g_yv = !yd && (t >= y_delay);
      @(negedge clk);
      if (xd) check("x_rdy_low_after_capture", 64'(m_xr), 64'd0);
      if (yd) check("y_rdy_low_after_capture", 64'(m_yr), 64'd0);
      if (g_xv && m_xr) xd = 1'b1;
      if (g_yv && m_yr) yd = 1'b1;
      if (xd && yd) e.cap = cyc + 1;
      @(posedge clk); #1;
      t++;
      if (t > 300) begin
        check("operand_accept_timeout", 64'(xd && yd), 64'd1);
        break;
      end
    end
    g_xv = 1'b0; g_yv = 1'b0;
    if (push && xd && yd) sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
    stall_en = 1'b0;
    g_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  // Random output stalls for the back-to-back phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_en) g_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Result monitor: pops the scoreboard on each output handshake.
  initial begin
    int   rise_cyc;
    logic vld_prev;
    exp_t e;
    rise_cyc = 0; vld_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_vld && !vld_prev) rise_cyc = cyc;
      vld_prev = m_vld;
      if (m_vld && g_rdy) begin
        if (sb.size() == 0) begin
          check("result_without_expectation", 64'(m_vld), 64'd0);
        end else begin
          e = sb.pop_front();
          check("sum", m_sum, e.sum);
          check("cout", 64'(m_cout), 64'(e.cout));
          check("ovf", 64'(m_ovf), 64'(e.ovf));
          check("latency_from_capture", 64'(rise_cyc - e.cap), 64'(e.lat + 1));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [63:0] rx, ry;
    logic        rop;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_sum", m_sum, 64'd0);
    check("rst_vld", 64'(m_vld), 64'd0);
    check("rst_x_rdy", 64'(m_xr), 64'd0);
    check("rst_y_rdy", 64'(m_yr), 64'd0);
    asyn_reset = 1'b0;
    #1 check("rdy_low_at_release", 64'(m_xr), 64'd0);
    @(negedge clk);
    check("x_rdy_after_first_edge", 64'(m_xr), 64'd1);
    check("y_rdy_after_first_edge", 64'(m_yr), 64'd1);
    @(posedge clk); #1;
    g_rdy = 1'b1;

    // 8/2: 0x7F + 0x01, both operands in the same cycle.
    sel = 0;
    drive_txn(64'h7F, 64'h01, OP_ADD, 0, 0, 1'b1, 64'h80, 1'b0, 1'b1);
    wait_drain();

    // 8/1: 0x05 - 0x07, Y three cycles ahead of X.
    sel = 1;
    drive_txn(64'h05, 64'h07, OP_SUB, 3, 0, 1'b1, 64'hFE, 1'b0, 1'b0);
    wait_drain();

    // 8/4: signed-overflowing subtract, then wrapping add.
    sel = 2;
    drive_txn(64'h80, 64'h01, OP_SUB, 0, 1, 1'b1, 64'h7F, 1'b1, 1'b1);
    drive_txn(64'hFF, 64'h01, OP_ADD, 1, 0, 1'b1, 64'h00, 1'b1, 1'b0);
    wait_drain();

    // Backpressure in DONE with a pending X offer.
    g_rdy = 1'b0;
    drive_txn(64'h12, 64'h34, OP_ADD, 0, 0, 1'b1, 64'h46, 1'b0, 1'b0);
    for (int i = 0; i < 60 && !m_vld; i++) begin
      @(posedge clk); #1;
    end
    check("bp_result_valid", 64'(m_vld), 64'd1);
    g_x = 64'hAA; g_op = OP_ADD; g_xv = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_sum_stable", m_sum, 64'h46);
      check("bp_cout_stable", 64'(m_cout), 64'd0);
      check("bp_vld_held", 64'(m_vld), 64'd1);
      check("bp_x_rdy_low", 64'(m_xr), 64'd0);
    end
    @(posedge clk); #1;
    g_rdy = 1'b1;
    @(posedge clk); #1;
    g_xv = 1'b0;
    @(negedge clk);
    check("bp_vld_dropped", 64'(m_vld), 64'd0);
    check("bp_x_rdy_rose", 64'(m_xr), 64'd1);
    check("bp_y_rdy_rose", 64'(m_yr), 64'd1);
    wait_drain();

    // 64/1: reset in the middle of a computation.
    sel = 3;
    drive_txn(64'h1, 64'h2, OP_ADD, 0, 0, 1'b1, 64'h3, 1'b0, 1'b0);
    wait_drain();
    drive_txn(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, OP_ADD, 0, 0, 1'b0,
              64'h0, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1 asyn_reset = 1'b1;
    #1;
    check("abort_sum", m_sum, 64'd0);
    check("abort_cout", 64'(m_cout), 64'd0);
    check("abort_ovf", 64'(m_ovf), 64'd0);
    check("abort_vld", 64'(m_vld), 64'd0);
    check("abort_x_rdy", 64'(m_xr), 64'd0);
    check("abort_y_rdy", 64'(m_yr), 64'd0);
    @(negedge clk);
    asyn_reset = 1'b0;
    @(negedge clk);
    check("abort_x_rdy_back", 64'(m_xr), 64'd1);
    check("abort_y_rdy_back", 64'(m_yr), 64'd1);
    @(posedge clk); #1;
    drive_txn(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, OP_ADD, 0, 0, 1'b1, 64'h0, 1'b1, 1'b0);
    wait_drain();

    // 16-bit builds, DIGIT 1..16: random back-to-back traffic with stalls.
    for (int s = 4; s < NI; s++) begin
      sel = s;
      stall_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        rx  = 64'($urandom_range(0, 16'hFFFF));
        ry  = 64'($urandom_range(0, 16'hFFFF));
        rop = 1'($urandom_range(0, 1));
        e   = model(16, rx, ry, rop);
        drive_txn(rx, ry, rop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'b1, e.sum, e.cout, e.ovf);
      end
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
